// File: rtl/key_loader_serial_pkg.sv
// -----------------------------------------------------------------------------
// keyld_pkg
// Shared constants and types for the serial key loader of the XOR-locked
// bench2G netlists.
//   KEY_W       : width of the flat KEYINPUT bus
//   CHUNK_W     : width of one stream beat
//   NCHUNK      : number of data beats (ceil(KEY_W/CHUNK_W))
//   CNT_W       : beat counter width (counts data beats plus the checksum beat)
//   LAST_W      : number of real key bits carried by the last data beat
//   PAD_MASK    : bits of the last data beat that must be zero
//   TIMEOUT_CYC_DEF : default inactivity limit for the optional timeout
// -----------------------------------------------------------------------------
package keyld_pkg;

    localparam int KEY_W   = 54;
    localparam int CHUNK_W = 8;
    localparam int NCHUNK  = (KEY_W + CHUNK_W - 1) / CHUNK_W;
    localparam int CNT_W   = $clog2(NCHUNK + 1);
    localparam int LAST_W  = KEY_W - (NCHUNK - 1) * CHUNK_W;

    localparam logic [CHUNK_W-1:0] PAD_MASK = ~({CHUNK_W{1'b1}} >> (CHUNK_W - LAST_W));

    localparam int TIMEOUT_CYC_DEF = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_ARMED,
        ST_ERROR
    } keyld_state_e;

endpackage

// File: rtl/key_loader_serial_if.sv
// -----------------------------------------------------------------------------
// key_loader_serial_if
// Byte-wide valid/ready key stream into the key loader.
//   in_data  : key chunk or checksum beat (source -> loader)
//   in_valid : source has a beat          (source -> loader)
//   in_ready : loader accepts a beat      (loader -> source)
// Modports: master = stream source, slave = key loader.
// -----------------------------------------------------------------------------
interface key_loader_serial_if;
    import keyld_pkg::*;

    logic [CHUNK_W-1:0] in_data;
    logic               in_valid;
    logic               in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/key_loader_serial_chk.sv
// -----------------------------------------------------------------------------
// keyld_chk
// XOR checksum accumulator and pad checker for one key load.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : restart accumulation (load start / zeroize)
//   acc_en    : an accepted beat (data or checksum) is on data
//   last_data : the accepted beat is the last data beat (pad bits live here)
//   data      : beat value
//   sum_ok    : XOR of all data beats equals the checksum beat
//   pad_ok    : no pad bit of the last data beat was set
// -----------------------------------------------------------------------------
module keyld_chk
    import keyld_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               acc_en,
    input  logic               last_data,
    input  logic [CHUNK_W-1:0] data,
    output logic               sum_ok,
    output logic               pad_ok
);

    logic [CHUNK_W-1:0] acc;
    logic               pad_bad;

    // The checksum beat is folded into the same XOR as the data beats, so a
    // correct checksum leaves the accumulator at zero; no copy of the
    // checksum beat has to be kept for the compare in CHECK.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            pad_bad <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            pad_bad <= 1'b0;
        end else if (acc_en) begin
            acc <= acc ^ data;
            if (last_data && ((data & PAD_MASK) != '0)) begin
                pad_bad <= 1'b1;
            end
        end
    end

    assign sum_ok = (acc == '0);
    assign pad_ok = ~pad_bad;

endmodule

// File: rtl/key_loader_serial.sv
// -----------------------------------------------------------------------------
// key_loader_serial
// Receives an unlock key as CHUNK_W-bit beats (LSB chunk first) followed by
// an XOR checksum beat, verifies it, and drives the KEYINPUT bus of the
// locked netlist. key_out stays zero unless a verified key is armed.
//   clk, rst    : clock, asynchronous active-high reset
//   cmd_start   : pulse, begin or restart a load (clears any armed key)
//   cmd_zeroize : pulse, clear everything and return to IDLE
//   strm        : slave side of the key stream (in_data/in_valid/in_ready)
//   key_out     : key bus, bit i drives KEYINPUT<i>
//   key_valid   : key_out carries a verified key
//   err         : last load failed
//   busy        : a load is in progress (LOAD or CHECK)
//   err_timeout : err was caused by stream inactivity (KEYLD_TIMEOUT_EN only)
// Optional feature: define KEYLD_TIMEOUT_EN to abort a LOAD that sees no
// accepted beat for TIMEOUT_CYC cycles.
// -----------------------------------------------------------------------------
module key_loader_serial
    import keyld_pkg::*;
`ifdef KEYLD_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
`endif
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_start,
    input  logic                 cmd_zeroize,
    key_loader_serial_if.slave   strm,
    output logic [KEY_W-1:0]     key_out,
    output logic                 key_valid,
    output logic                 err,
`ifdef KEYLD_TIMEOUT_EN
    output logic                 err_timeout,
`endif
    output logic                 busy
);

    keyld_state_e     state, state_nx;
    logic [CNT_W-1:0] beat_cnt;
    logic [KEY_W-1:0] shadow;
    logic             accept, csum_beat, last_data, any_cmd;
    logic             sum_ok, pad_ok, timeout_hit;

    // Commands take precedence over the handshake: a beat offered in the same
    // cycle as cmd_start or cmd_zeroize is dropped.
    assign any_cmd   = cmd_start | cmd_zeroize;
    assign accept    = strm.in_valid & strm.in_ready & ~any_cmd;
    assign last_data = accept && (beat_cnt == CNT_W'(NCHUNK - 1));
    assign csum_beat = accept && (beat_cnt == CNT_W'(NCHUNK));

    keyld_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .clr       (any_cmd),
        .acc_en    (accept),
        .last_data (last_data),
        .data      (strm.in_data),
        .sum_ok    (sum_ok),
        .pad_ok    (pad_ok)
    );

`ifdef KEYLD_TIMEOUT_EN
    logic [15:0] idle_cnt;

    // Counts cycles in LOAD since LOAD entry or the last accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state != ST_LOAD || any_cmd || accept) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 16'd1;
        end
    end

    assign timeout_hit = (state == ST_LOAD) && !any_cmd && !accept &&
                         (idle_cnt == 16'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (any_cmd) begin
            err_timeout <= 1'b0;
        end else if (timeout_hit) begin
            err_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        if (cmd_zeroize) begin
            state_nx = ST_IDLE;
        end else if (cmd_start) begin
            state_nx = ST_LOAD;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (csum_beat) begin
                        state_nx = ST_CHECK;
                    end else if (timeout_hit) begin
                        state_nx = ST_ERROR;
                    end
                end
                ST_CHECK: state_nx = (sum_ok && pad_ok) ? ST_ARMED : ST_ERROR;
                default:  state_nx = state;
            endcase
        end
    end

    // State-decoded outputs; in_ready depends on the registered state only.
    always_comb begin
        strm.in_ready = (state == ST_LOAD);
        busy          = (state == ST_LOAD) || (state == ST_CHECK);
    end

    // Beat counter: wraps after the checksum beat, which is harmless because
    // LOAD is left on that same edge and every LOAD entry clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (any_cmd) begin
            beat_cnt <= '0;
        end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Shadow register and key bus. The key is only copied out on the
    // CHECK -> ARMED edge, so a partial key never reaches key_out.
    // NOTE: the shadow holds secret material, so it is explicitly cleared on
    // reset rather than left to power-up contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else if (any_cmd) begin
            shadow    <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept && !csum_beat) begin
                if (last_data) begin
                    // Pad bits of the last beat are checked, never stored.
                    shadow[KEY_W-1 -: LAST_W] <= strm.in_data[LAST_W-1:0];
                end else begin
                    shadow[int'(beat_cnt) * CHUNK_W +: CHUNK_W] <= strm.in_data;
                end
            end
            if (state == ST_CHECK && state_nx == ST_ARMED) begin
                key_out   <= shadow;
                key_valid <= 1'b1;
            end
            if (state != ST_ERROR && state_nx == ST_ERROR) begin
                shadow <= '0;
                err    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_loader_serial.sv
// -----------------------------------------------------------------------------
// tb_key_loader_serial
// Directed and randomized stimulus for key_loader_serial. Expected keys and
// pass/fail outcomes come from ref_model, which rebuilds the key from the
// beat list with plain arithmetic. Define KEYLD_TIMEOUT_EN to exercise the
// inactivity timeout with TIMEOUT_CYC = 16.
// -----------------------------------------------------------------------------
module tb_key_loader_serial;
    import keyld_pkg::*;

    typedef byte unsigned beats_t [NCHUNK+1];

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_start;
    logic             cmd_zeroize;
    logic [KEY_W-1:0] key_out;
    logic             key_valid;
    logic             err;
    logic             busy;
`ifdef KEYLD_TIMEOUT_EN
    logic             err_timeout;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    key_loader_serial_if itf ();

    always #5 clk = ~clk;

`ifdef KEYLD_TIMEOUT_EN
    key_loader_serial #(.TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cmd_zeroize (cmd_zeroize),
        .strm        (itf.slave),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .err         (err),
        .err_timeout (err_timeout),
        .busy        (busy)
    );
`else
    key_loader_serial dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cmd_zeroize (cmd_zeroize),
        .strm        (itf.slave),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .err         (err),
        .busy        (busy)
    );
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outcome of a full load: key = data beats concatenated LSB
    // first, valid only if the checksum beat is the XOR of the data beats and
    // the last data beat fits in the remaining key bits.
    function automatic void ref_model(input beats_t b, output bit ok, output logic [KEY_W-1:0] key);
        logic [NCHUNK*CHUNK_W-1:0] full;
        byte unsigned              x;
        full = '0;
        x    = 8'h00;
        for (int i = 0; i < NCHUNK; i++) begin
            full = full | ((NCHUNK*CHUNK_W)'(b[i]) << (CHUNK_W * i));
            x    = x ^ b[i];
        end
        ok  = (x == b[NCHUNK]) && (int'(b[NCHUNK-1]) < (1 << LAST_W));
        key = ok ? full[KEY_W-1:0] : '0;
    endfunction

    // One-cycle cmd_start, optionally with a junk beat offered alongside.
    task automatic start(input bit junk);
        cmd_start    = 1'b1;
        itf.in_valid = junk;
        itf.in_data  = 8'($urandom);
        step();
        cmd_start    = 1'b0;
        itf.in_valid = 1'b0;
    endtask

    // Offer the first n beats of b; with stall set, in_valid drops randomly.
    task automatic send(input beats_t b, input int n, input bit stall, output int sent);
        int   guard;
        logic rdy;
        bit   v;
        guard = 0;
        sent  = 0;
        while (sent < n && guard < 400) begin
            v            = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            itf.in_valid = v;
            itf.in_data  = v ? b[sent] : 8'($urandom);
            rdy          = itf.in_ready;
            step();
            if (v && rdy) sent++;
            guard++;
        end
        itf.in_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input beats_t b, input bit stall);
        int               sent;
        bit               ok;
        logic [KEY_W-1:0] key;
        start(1'b1);
        check({tag, "_start_key"},   64'(key_out), 64'd0);
        check({tag, "_start_valid"}, 64'(key_valid), 64'd0);
        check({tag, "_start_err"},   64'(err), 64'd0);
        check({tag, "_start_busy"},  64'(busy), 64'd1);
        send(b, NCHUNK + 1, stall, sent);
        check({tag, "_beats_taken"}, 64'(sent), 64'(NCHUNK + 1));
        check({tag, "_check_valid"}, 64'(key_valid), 64'd0);
        check({tag, "_check_busy"},  64'(busy), 64'd1);
        step();
        ref_model(b, ok, key);
        check({tag, "_valid"}, 64'(key_valid), 64'(ok));
        check({tag, "_key"},   64'(key_out), 64'(key));
        check({tag, "_err"},   64'(err), 64'(!ok));
        check({tag, "_busy"},  64'(busy), 64'd0);
    endtask

    initial begin
        beats_t           b;
        logic [63:0]      rk;
        int               sent;
        int               mode;

        rst          = 1'b1;
        cmd_start    = 1'b0;
        cmd_zeroize  = 1'b0;
        itf.in_valid = 1'b0;
        itf.in_data  = '0;
        #1;
        check("rst_key",   64'(key_out), 64'd0);
        check("rst_valid", 64'(key_valid), 64'd0);
        check("rst_err",   64'(err), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_ready", 64'(itf.in_ready), 64'd0);
        step();
        step();
        rst = 1'b0;

        // Beats offered in IDLE are ignored.
        b = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        send(b, 3, 1'b0, sent);
        check("idle_beats_ignored", 64'(sent), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);

        // All-ones key.
        b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3F, 8'h3F};
        do_load("ones", b, 1'b0);
        check("ones_exact", 64'(key_out), 64'h003F_FFFF_FFFF_FFFF);

        // Beats offered in ARMED are ignored and the key holds.
        send(b, 3, 1'b0, sent);
        check("armed_beats_ignored", 64'(sent), 64'd0);
        check("armed_key_hold", 64'(key_valid), 64'd1);

        // Pad violation (reload from ARMED clears key first inside do_load).
        b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F};
        do_load("pad", b, 1'b0);

        // Zeroize from ERROR clears err.
        cmd_zeroize = 1'b1;
        step();
        cmd_zeroize = 1'b0;
        check("zero_from_err", 64'(err), 64'd0);

        // Checksum mismatch, then recovery.
        b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h01};
        do_load("mismatch", b, 1'b0);
        b[NCHUNK] = 8'h00;
        do_load("recover", b, 1'b1);
        check("recover_exact", 64'(key_out), 64'h0007_0605_0403_0201);

        // Random keys, random stalls, occasionally corrupted.
        for (int t = 0; t < 12; t++) begin
            rk   = {$urandom, $urandom} & ((64'd1 << KEY_W) - 64'd1);
            mode = $urandom_range(0, 3);
            b[NCHUNK] = 8'h00;
            for (int i = 0; i < NCHUNK; i++) begin
                b[i]      = 8'(rk >> (CHUNK_W * i));
                b[NCHUNK] = b[NCHUNK] ^ b[i];
            end
            if (mode == 1) b[NCHUNK] = b[NCHUNK] ^ 8'(1 << $urandom_range(0, 7));
            if (mode == 2) begin
                b[NCHUNK-1] = b[NCHUNK-1] | 8'h80;
                b[NCHUNK]   = b[NCHUNK] ^ 8'h80;
            end
            do_load($sformatf("rand%0d", t), b, 1'b1);
        end

        // Restart mid-load: the partial beats must not leak into the next key.
        start(1'b0);
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h07, 8'h00};
        send(b, 3, 1'b0, sent);
        b = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h0F, 8'hF0, 8'h12, 8'h00};
        for (int i = 0; i < NCHUNK; i++) b[NCHUNK] = b[NCHUNK] ^ b[i];
        do_load("restart", b, 1'b0);

        // cmd_start together with cmd_zeroize mid-load: zeroize wins.
        start(1'b0);
        send(b, 3, 1'b0, sent);
        cmd_start   = 1'b1;
        cmd_zeroize = 1'b1;
        step();
        cmd_start   = 1'b0;
        cmd_zeroize = 1'b0;
        check("zs_busy",  64'(busy), 64'd0);
        check("zs_ready", 64'(itf.in_ready), 64'd0);
        check("zs_key",   64'(key_out), 64'd0);
        check("zs_valid", 64'(key_valid), 64'd0);
        check("zs_err",   64'(err), 64'd0);

`ifdef KEYLD_TIMEOUT_EN
        // Timeout: three beats then silence; err after 16 cycles.
        start(1'b0);
        send(b, 3, 1'b0, sent);
        for (int k = 1; k < 16; k++) step();
        check("tmo_early_err", 64'(err), 64'd0);
        check("tmo_early_busy", 64'(busy), 64'd1);
        step();
        check("tmo_err",   64'(err), 64'd1);
        check("tmo_flag",  64'(err_timeout), 64'd1);
        check("tmo_key",   64'(key_out), 64'd0);
        check("tmo_busy",  64'(busy), 64'd0);
        start(1'b0);
        check("tmo_flag_clr", 64'(err_timeout), 64'd0);
        cmd_zeroize = 1'b1;
        step();
        cmd_zeroize = 1'b0;
`else
        // Without the timeout, LOAD waits indefinitely.
        start(1'b0);
        send(b, 3, 1'b0, sent);
        for (int k = 0; k < 40; k++) step();
        check("wait_busy", 64'(busy), 64'd1);
        check("wait_err",  64'(err), 64'd0);
        cmd_zeroize = 1'b1;
        step();
        cmd_zeroize = 1'b0;
`endif

        // Async reset mid-load takes effect without a clock edge.
        start(1'b0);
        send(b, 2, 1'b0, sent);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy",  64'(busy), 64'd0);
        check("arst_ready", 64'(itf.in_ready), 64'd0);
        check("arst_key",   64'(key_out), 64'd0);
        step();
        rst = 1'b0;

        b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3F, 8'h3F};
        do_load("post_rst", b, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/key_loader_serial.md
Name: key_loader_serial

Overview:
- Key-provisioning front end for the XOR-locked combinational benchmarks in bench2G.
- Receives the unlock key as byte-wide chunks over a valid/ready stream, verifies a trailing checksum, and drives the flat KEYINPUT bus of the locked netlist.
- Holds the key bus at all-zero (locked) until a complete, verified key is armed.
- Zeroizes on command, on error, or on reload.

Parameters:
- KEY_W, 54: key width; bit i drives KEYINPUT<i>.
- CHUNK_W, 8: width of one stream beat.
- NCHUNK, derived as ceil(KEY_W/CHUNK_W) = 7: number of data beats.

Ports:
- clk in 1: single clock.
- rst in 1: asynchronous, active-high reset.
- cmd_start in 1: one-cycle pulse; begin or restart a key load.
- cmd_zeroize in 1: one-cycle pulse; clear the key and return to IDLE.
- in_data in CHUNK_W: key chunk or checksum beat.
- in_valid in 1: source has a beat.
- in_ready out 1: block accepts a beat.
- key_out out KEY_W: key bus to the locked netlist.
- key_valid out 1: key_out carries a verified key.
- err out 1: last load failed.
- busy out 1: state is LOAD or CHECK.

Behaviour:
- Reset (async, rst=1): state=IDLE. key_out=0, key_valid=0, err=0, busy=0, in_ready=0. Shadow register, beat counter and checksum accumulator are all 0.
- States: IDLE, LOAD, CHECK, ARMED, ERROR.
- in_ready = (state==LOAD). It is registered-state-derived only, with no combinational path from in_valid.
- A beat transfers on a rising edge with in_valid & in_ready. in_data must be stable while in_valid=1 and in_ready=0.
- Beat order:
  - Beats 0..NCHUNK-1 are data. Beat k loads shadow[k*CHUNK_W +: CHUNK_W], LSB chunk first.
  - Beat NCHUNK is the checksum: the XOR of all NCHUNK data beats.
  - In the last data beat, bits above KEY_W-(NCHUNK-1)*CHUNK_W (bits [7:6] for defaults) are pad and must be 0.
- Checksum accumulator XORs each data beat. The counter is $clog2(NCHUNK+1) bits wide and saturates at no value; it is cleared on every LOAD entry.
- Transitions:
  - IDLE -> LOAD on cmd_start.
  - LOAD -> CHECK on the edge that accepts the checksum beat.
  - CHECK, exactly one cycle:
    - -> ARMED if checksum matches and pad is zero.
    - -> ERROR otherwise.
  - ARMED -> LOAD on cmd_start. key_out clears to 0 and key_valid to 0 on that same edge.
  - ERROR -> LOAD on cmd_start.
  - Any state -> IDLE on cmd_zeroize. Shadow, key_out, key_valid and err are all cleared.
- Priority: cmd_zeroize > cmd_start > beat handshake.
  - cmd_start during LOAD or CHECK restarts the load: counter, accumulator and shadow are cleared, and any beat presented that cycle is discarded.
- Entering LOAD clears shadow and err.
- key_out/key_valid update on the edge leaving CHECK. Latency from the checksum-accept edge to key_valid=1 is one cycle.
- key_out is 0 in every state except ARMED. A partial key is never visible on key_out.
- ERROR: err=1, key_out=0, held until cmd_start or cmd_zeroize.
- busy=1 in LOAD and CHECK.

Optional Feature:
- Macro: KEYLD_TIMEOUT_EN.
- When defined:
  - A 16-bit inactivity counter runs in LOAD and resets on each accepted beat and on LOAD entry.
  - Reaching parameter TIMEOUT_CYC (default 1024) forces LOAD -> ERROR on the next edge, with shadow cleared.
  - An extra output err_timeout (1 bit) is set with err for that cause.
- When undefined: no counter and no err_timeout port. LOAD waits indefinitely.

Decomposition:
- Package keyld_pkg:
  - State enum keyld_state_e.
  - Constants KEY_W, CHUNK_W, NCHUNK, PAD_MASK (last-chunk pad mask), and TIMEOUT_CYC default.
- Sub-module keyld_chk: XOR checksum accumulator with clear/accumulate/compare and a pad-check output.
- FSM and shadow register live in key_loader_serial.

Test Plan:
- All-ones key: cmd_start; beats FF,FF,FF,FF,FF,FF,3F, checksum 3F. Expect key_valid=1 and key_out=54'h3F_FFFF_FFFF_FFFF one cycle after checksum accept; err=0.
- Pad violation: same as above, but last data beat 7F and checksum 7F. Expect err=1, key_valid=0, key_out=0.
- Checksum mismatch and recovery: key 01,02,03,04,05,06,07 sent with checksum 00 (correct is 00^01^02^03^04^05^06^07=00). Send 01 to force a mismatch: err=1. Then cmd_start and resend with checksum 00: key_out=54'h07_0605_0403_0201, err=0.
- Backpressure and stalls:
  - in_valid toggled randomly: identical result, no beat lost or duplicated.
  - in_ready=0 throughout IDLE/ARMED: beats presented there are ignored.
- Reload and zeroize:
  - In ARMED, cmd_start: key_out=0 next cycle.
  - cmd_start together with cmd_zeroize mid-LOAD: state IDLE, all outputs 0.
  - Async rst asserted mid-LOAD: outputs 0 immediately.
- KEYLD_TIMEOUT_EN, TIMEOUT_CYC=16: send 3 beats then idle. Expect err=1 and err_timeout=1 sixteen cycles after the last accept, key_out=0.
